// File: rtl/flip_engine_pf.sv
// Spin flip engine: XORs prefetched flip icons onto a spin stream, one icon per
// repeat_i accepted spins, in bypass, one-shot or wrap-around window sequencing.
module flip_engine_pf #(
  parameter int NUM_SPIN        = 256,
  parameter int FLIP_ICON_DEPTH = 1024,
  parameter int ADDR_W          = $clog2(FLIP_ICON_DEPTH) + 1,
  parameter int RD_LATENCY      = 1,
  parameter int PREFETCH_DEPTH  = 4,
  parameter int CNT_W           = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                flush_i,
  input  logic [1:0]          mode_i,
  input  logic [CNT_W-1:0]    repeat_i,
  input  logic [ADDR_W-1:0]   icon_base_raddr_i,
  input  logic [ADDR_W-1:0]   icon_last_raddr_plus_one_i,
  input  logic                prev_spin_valid_i,
  input  logic [NUM_SPIN-1:0] prev_spin_i,
  output logic                prev_spin_ready_o,
  output logic                flipped_spin_valid_o,
  output logic [NUM_SPIN-1:0] flipped_spin_o,
  input  logic                flipped_spin_ready_i,
  output logic                flip_ren_o,
  output logic [ADDR_W-1:0]   flip_raddr_o,
  input  logic [NUM_SPIN-1:0] flip_rdata_i,
  output logic                icon_finish_o,
  output logic [CNT_W-1:0]    icon_count_o
);

  localparam int PTR_W = (PREFETCH_DEPTH > 1) ? $clog2(PREFETCH_DEPTH) : 1;
  localparam int OCC_W = $clog2(PREFETCH_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_state_next;
  logic [1:0]            r_mode;
  logic [CNT_W-1:0]      r_repeat;
  logic [ADDR_W-1:0]     r_raddr, w_raddr_next;
  logic [RD_LATENCY-1:0] r_inflight;
  logic [NUM_SPIN-1:0]   r_fifo [PREFETCH_DEPTH];
  logic [PTR_W-1:0]      r_wptr, r_rptr;
  logic [OCC_W-1:0]      r_occ;
  logic [CNT_W-1:0]      r_use, r_icon_count;
  logic                  r_out_valid;
  logic [NUM_SPIN-1:0]   r_out_spin;

  logic [31:0]           w_inflight_cnt;
  logic [CNT_W-1:0]      w_rep_eff;
  logic w_mode_bypass, w_bypass, w_ren, w_push, w_ready, w_in_hs, w_out_hs;
  logic w_use_last, w_pop;

  // Bypass is judged from the live mode while idle, since mode is re-latched every idle cycle.
  assign w_mode_bypass = (mode_i == 2'd0) || (mode_i == 2'd3);
  assign w_bypass      = (r_state == S_IDLE) && w_mode_bypass;

  always_comb begin
    w_inflight_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight_cnt = w_inflight_cnt + {31'd0, r_inflight[i]};
    end
  end

  assign w_ren  = (r_state == S_FETCH) && en_i && !flush_i &&
                  ((32'(r_occ) + w_inflight_cnt) < 32'(PREFETCH_DEPTH));
  assign w_push = r_inflight[RD_LATENCY-1];

  assign w_ready   = en_i && !flush_i && (r_state != S_DONE) &&
                     (w_bypass || (r_occ != '0)) &&
                     (!r_out_valid || flipped_spin_ready_i);
  assign w_in_hs   = prev_spin_valid_i && w_ready;
  assign w_out_hs  = en_i && r_out_valid && flipped_spin_ready_i;
  assign w_rep_eff = (r_repeat == '0) ? CNT_W'(1) : r_repeat;
  assign w_use_last = (r_use + CNT_W'(1)) == w_rep_eff;
  assign w_pop     = w_in_hs && !w_bypass && w_use_last;

  always_comb begin
    w_state_next = r_state;
    w_raddr_next = r_raddr;
    case (r_state)
      S_IDLE: begin
        if (en_i && !w_mode_bypass) begin
          w_raddr_next = icon_base_raddr_i;
          w_state_next = (icon_base_raddr_i == icon_last_raddr_plus_one_i) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_ren) begin
          if ((r_raddr + ADDR_W'(1)) == icon_last_raddr_plus_one_i) begin
            if (r_mode == 2'd2) begin
              w_raddr_next = icon_base_raddr_i;
            end else begin
              w_raddr_next = r_raddr + ADDR_W'(1);
              w_state_next = S_DRAIN;
            end
          end else begin
            w_raddr_next = r_raddr + ADDR_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // Look through a same-cycle pop so DONE follows the final spin directly.
        if (en_i && (w_inflight_cnt == '0) && ((r_occ == '0) || ((r_occ == OCC_W'(1)) && w_pop))) begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = r_state;
    endcase
  end

  // Icon storage has no reset; only pointers and occupancy carry state.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wptr] <= flip_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_mode       <= 2'd0;
      r_repeat     <= '0;
      r_raddr      <= '0;
      r_inflight   <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_occ        <= '0;
      r_use        <= '0;
      r_icon_count <= '0;
      r_out_valid  <= 1'b0;
      r_out_spin   <= '0;
    end else if (flush_i) begin
      r_state      <= S_IDLE;
      r_inflight   <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_occ        <= '0;
      r_use        <= '0;
      r_icon_count <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_raddr <= w_raddr_next;
      if (r_state == S_IDLE && en_i) begin
        r_mode   <= mode_i;
        r_repeat <= repeat_i;
      end
      // The read tracker keeps shifting with en_i low so returning data is never lost.
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        r_inflight[i] <= r_inflight[i-1];
      end
      r_inflight[0] <= w_ren;
      if (w_push) begin
        r_wptr <= (r_wptr == PTR_W'(PREFETCH_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PTR_W'(PREFETCH_DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + OCC_W'(1);
      end else if (!w_push && w_pop) begin
        r_occ <= r_occ - OCC_W'(1);
      end
      if (w_in_hs && !w_bypass) begin
        if (w_use_last) begin
          r_use        <= '0;
          r_icon_count <= r_icon_count + CNT_W'(1);
        end else begin
          r_use <= r_use + CNT_W'(1);
        end
      end
      if (w_in_hs) begin
        r_out_valid <= 1'b1;
        r_out_spin  <= w_bypass ? prev_spin_i : (prev_spin_i ^ r_fifo[r_rptr]);
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign prev_spin_ready_o    = w_ready;
  assign flipped_spin_valid_o = r_out_valid;
  assign flipped_spin_o       = r_out_spin;
  assign flip_ren_o           = w_ren;
  assign flip_raddr_o         = r_raddr;
  assign icon_finish_o        = (r_state == S_DONE);
  assign icon_count_o         = r_icon_count;

endmodule

// File: tb/tb_flip_engine_pf.sv
// Scoreboard bench for flip_engine_pf: randomized spins, icon memory model and a
// window-level reference of which icon each accepted spin must be flipped with.
module tb_flip_engine_pf;
  localparam int NS = 32, DEPTH = 16, AW = 5, L = 3, PD = 4, CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_ni, en_cfg, flush_i, pv, rdy_cfg;
  logic [1:0]    mode_i;
  logic [CW-1:0] repeat_i;
  logic [AW-1:0] base, last;
  logic [NS-1:0] ps;
  logic          ready_o, fv, ren, finish;
  logic [NS-1:0] fs, rdata;
  logic [AW-1:0] raddr;
  logic [CW-1:0] cnt;
  logic tog_on = 1'b0, rnd_en = 1'b0, tog_val = 1'b0, en_rnd = 1'b1, lat_chk = 1'b0;
  logic en_w, rdy_w;
  assign en_w  = rnd_en ? en_rnd : en_cfg;
  assign rdy_w = tog_on ? tog_val : rdy_cfg;

  flip_engine_pf #(.NUM_SPIN(NS), .FLIP_ICON_DEPTH(DEPTH), .RD_LATENCY(L),
                   .PREFETCH_DEPTH(PD), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_w), .flush_i(flush_i), .mode_i(mode_i),
    .repeat_i(repeat_i), .icon_base_raddr_i(base), .icon_last_raddr_plus_one_i(last),
    .prev_spin_valid_i(pv), .prev_spin_i(ps), .prev_spin_ready_o(ready_o),
    .flipped_spin_valid_o(fv), .flipped_spin_o(fs), .flipped_spin_ready_i(rdy_w),
    .flip_ren_o(ren), .flip_raddr_o(raddr), .flip_rdata_i(rdata),
    .icon_finish_o(finish), .icon_count_o(cnt));

  int n_checks = 0, n_errors = 0, cyc = 0;
  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Icon memory with RD_LATENCY-cycle read pipeline
  logic [NS-1:0] mem [DEPTH];
  logic [AW-1:0] pa [L];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pa[0] <= raddr;
    for (int i = 1; i < L; i++) pa[i] <= pa[i-1];
  end
  assign rdata = mem[pa[L-1][3:0]];

  always @(posedge clk) begin
    #1;
    tog_val = ~tog_val;
    en_rnd  = ($urandom_range(0, 4) != 0);
  end

  // Reference: the k-th accepted spin of a run uses icon base + k/rep (wrapped for mode 2).
  function automatic logic [NS-1:0] ref_icon(input int k);
    int rep, win, idx;
    rep = (repeat_i == 0) ? 1 : int'(repeat_i);
    win = int'(last) - int'(base);
    if (mode_i == 2'd1) idx = int'(base) + k / rep;
    else if (mode_i == 2'd2) idx = int'(base) + (k / rep) % win;
    else return '0;
    return mem[idx % DEPTH];
  endfunction

  typedef struct { logic [NS-1:0] d; int c; } exp_t;
  exp_t q[$];
  int k_in = 0, first_hs = -1, last_hs = -1;

  always @(negedge clk) begin : in_mon
    exp_t e;
    if (!rst_ni || flush_i) begin
      k_in = 0; first_hs = -1; last_hs = -1;
    end else if (pv && ready_o) begin
      if (mode_i == 2'd1)
        check(k_in < (int'(last) - int'(base)) * ((repeat_i == 0) ? 1 : int'(repeat_i)),
              "window_overrun", 64'(k_in), 64'(int'(last) - int'(base)));
      e.d = ps ^ ref_icon(k_in);
      e.c = cyc;
      q.push_back(e);
      k_in++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
    end
  end

  bit hold = 1'b0;
  logic [NS-1:0] hold_d;
  always @(negedge clk) begin : out_mon
    exp_t e;
    if (!rst_ni || flush_i) begin
      q.delete();
      hold = 1'b0;
    end else begin
      if (hold) check(fv && fs == hold_d, "stall_stable", {fv, fs}, {1'b1, hold_d});
      if (fv && rdy_w && en_w) begin
        check(q.size() != 0, "unexpected_output", fs, 0);
        if (q.size() != 0) begin
          e = q.pop_front();
          check(fs == e.d, "spin_data", fs, e.d);
          if (lat_chk) check(cyc == e.c + 1, "latency", 64'(cyc - e.c), 1);
        end
      end
      hold   = fv && !(rdy_w && en_w);
      hold_d = fs;
    end
  end

  int reads = 0;
  bit rfirst = 1'b1;
  logic [AW-1:0] exp_addr;
  always @(negedge clk) begin : rd_mon
    if (!rst_ni || flush_i) begin
      reads = 0; rfirst = 1'b1;
    end else if (ren) begin
      if (rfirst) exp_addr = base;
      check(raddr == exp_addr, "read_addr", raddr, exp_addr);
      reads++;
      rfirst = 1'b0;
      exp_addr = exp_addr + 1'b1;
      if (exp_addr == last) exp_addr = base;
    end
  end

  task automatic send(input int n, input int kind, input int maxw, output int acc);
    int w;
    bit hs;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      pv = 1'b1;
      if (kind == 1) ps = '0;
      else if (kind == 2 && i == 0) ps = 32'hA5A5A5A5;
      else if (kind == 2 && i == 1) ps = 32'h5A5A5A5A;
      else ps = $urandom;
      w = 0; hs = 1'b0;
      while (!hs && w < maxw) begin
        @(negedge clk);
        hs = ready_o;
        w++;
      end
      @(posedge clk); #1;
      if (!hs) break;
      acc++;
    end
    pv = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((q.size() != 0 || fv) && w < 200) begin
      @(negedge clk);
      w++;
    end
    check(q.size() == 0 && !fv, "drain", 64'(q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic start_run(input logic [1:0] m, input int b, input int e, input int r);
    en_cfg = 1'b0; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; mode_i = m; base = AW'(b); last = AW'(e); repeat_i = CW'(r);
    en_cfg = 1'b1;
  endtask

  task automatic check_reset_outputs();
    check(ready_o == 0, "rst_ready", ready_o, 0);
    check(fv == 0, "rst_valid", fv, 0);
    check(fs == 0, "rst_spin", fs, 0);
    check(ren == 0, "rst_ren", ren, 0);
    check(raddr == 0, "rst_raddr", raddr, 0);
    check(finish == 0, "rst_finish", finish, 0);
    check(cnt == 0, "rst_count", cnt, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst_ni = 1'b0; en_cfg = 1'b0; flush_i = 1'b0; mode_i = 2'd0; repeat_i = 1;
    base = '0; last = '0; pv = 1'b0; ps = '0; rdy_cfg = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = (i < 4) ? (32'd1 << i) : $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // bypass: spins pass through unchanged one cycle later, no icon reads
    lat_chk = 1'b1; en_cfg = 1'b1; mode_i = 2'd0;
    send(6, 2, 20, acc);
    check(acc == 6, "bypass_accepted", acc, 6);
    drain();
    check(reads == 0, "bypass_reads", reads, 0);
    lat_chk = 1'b0;

    // one-shot window 0..3, repeat 1: fifth spin must stall
    start_run(2'd1, 0, 4, 1);
    send(6, 1, 30, acc);
    check(acc == 4, "oneshot_accepted", acc, 4);
    drain();
    check(finish == 1, "oneshot_finish", finish, 1);
    check(reads == 4, "oneshot_reads", reads, 4);
    check(cnt == 4, "oneshot_count", cnt, 4);
    @(negedge clk);
    check(ready_o == 0, "done_ready", ready_o, 0);
    @(posedge clk); #1;

    // wrap window 2..3, repeat 3: full throughput after the first icon arrives
    start_run(2'd2, 2, 4, 3);
    lat_chk = 1'b1;
    send(12, 0, 50, acc);
    check(acc == 12, "wrap_accepted", acc, 12);
    check(last_hs - first_hs == 11, "wrap_throughput", 64'(last_hs - first_hs), 11);
    drain();
    check(cnt == 4, "wrap_count", cnt, 4);
    lat_chk = 1'b0;

    // backpressure toggling plus random enable gaps
    start_run(2'd2, 1, 6, 2);
    tog_on = 1'b1; rnd_en = 1'b1;
    send(40, 0, 100, acc);
    check(acc == 40, "bp_accepted", acc, 40);
    drain();
    tog_on = 1'b0; rnd_en = 1'b0;
    check(cnt == 20, "bp_count", cnt, 20);

    // flush with two reads in flight; stale returns must not reach the FIFO
    start_run(2'd1, 0, 8, 1);
    repeat (3) begin @(posedge clk); #1; end
    check(reads == 2, "inflight_reads", reads, 2);
    flush_i = 1'b1; en_cfg = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    base = AW'(5); en_cfg = 1'b1;
    send(3, 0, 30, acc);
    check(acc == 3, "reflush_accepted", acc, 3);
    drain();
    check(cnt == 3, "reflush_count", cnt, 3);
    check(reads == 3, "reflush_reads", reads, 3);

    // empty window: straight to DONE with zero reads
    start_run(2'd1, 3, 3, 1);
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    check(finish == 1, "empty_finish", finish, 1);
    check(reads == 0, "empty_reads", reads, 0);
    check(ready_o == 0, "empty_ready", ready_o, 0);
    @(posedge clk); #1;

    // reset in the middle of FETCH
    start_run(2'd2, 0, 8, 1);
    repeat (2) begin @(posedge clk); #1; end
    rst_ni = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_ni = 1'b1;
    en_cfg = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
